bsg_zynq_axil_master: RTL and testbench

Single-outstanding AXI4-Lite master that lets PL logic issue register reads and writes over a simple valid/ready command interface. It is the initiator counterpart to `bsg_zynq_pl_shell`: PL accelerators use it to reach PS-side or peer AXI-Lite slaves, such as an HP/ACP-attached CSR block or another PL shell in loopback benches. Commands are serialized, with exactly one AXI transaction in flight. Each command returns one response beat carrying data and error status.

---
 rtl/bsg_zynq_axil_master.sv | 206 ++++++++++++++++++++
 tb/tb_bsg_zynq_axil_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_zynq_axil_master.sv
// bsg_zynq_axil_master
// Single-outstanding AXI4-Lite master. PL logic hands in one read or write
// command at a time over a valid/ready port; the block runs the matching AXI
// transaction and returns a single response beat carrying data and error
// status. Every AXI output is a function of registered state only, so there
// is no combinational path from any AXI input to any AXI output.
module bsg_zynq_axil_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 10,
    parameter int err_count_width_p  = 8
) (
    input  logic                              aclk,
    input  logic                              aresetn,

    // command port
    input  logic                              cmd_v_i,
    output logic                              cmd_ready_o,
    input  logic                              cmd_we_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_data_i,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_strb_i,

    // response port
    output logic                              rsp_v_o,
    input  logic                              rsp_yumi_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data_o,
    output logic                              rsp_we_o,
    output logic                              rsp_err_o,
    output logic [err_count_width_p-1:0]      err_count_o,

    // AXI4-Lite write address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,

    // AXI4-Lite write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,

    // AXI4-Lite write response channel
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,

    // AXI4-Lite read address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,

    // AXI4-Lite read data channel
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;

    // holding registers for the command currently in flight
    logic                            r_we;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_data;
    logic [STRB_W-1:0]               r_strb;

    // AW and W complete independently; each remembers its own handshake
    logic                            r_aw_done;
    logic                            r_w_done;

    // captured response
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_data;
    logic                            r_rsp_err;
    logic [err_count_width_p-1:0]    r_err_count;

    logic                            w_cmd_fire;
    logic                            w_aw_fire;
    logic                            w_w_fire;
    logic                            w_wr_done;
    logic                            w_b_fire;
    logic                            w_r_fire;
    logic                            w_cap_err;

    // outputs decoded from state and registers only
    assign cmd_ready_o   = (r_state == S_IDLE);
    assign rsp_v_o       = (r_state == S_RSP);
    assign rsp_data_o    = r_rsp_data;
    assign rsp_we_o      = r_we;
    assign rsp_err_o     = r_rsp_err;
    assign err_count_o   = r_err_count;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (r_state == S_WADDR) & ~r_aw_done;
    assign m_axi_wdata   = r_data;
    assign m_axi_wstrb   = r_strb;
    assign m_axi_wvalid  = (r_state == S_WADDR) & ~r_w_done;
    assign m_axi_bready  = (r_state == S_WRESP);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (r_state == S_RADDR);
    assign m_axi_rready  = (r_state == S_RDATA);

    // handshake events
    assign w_cmd_fire = cmd_v_i & cmd_ready_o;
    assign w_aw_fire  = m_axi_awvalid & m_axi_awready;
    assign w_w_fire   = m_axi_wvalid & m_axi_wready;
    // both halves of the write are done, counting handshakes landing this cycle
    assign w_wr_done  = (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);
    assign w_b_fire   = m_axi_bvalid & m_axi_bready;
    assign w_r_fire   = m_axi_rvalid & m_axi_rready;
    assign w_cap_err  = (w_b_fire & (m_axi_bresp != 2'b00))
                      | (w_r_fire & (m_axi_rresp != 2'b00));

    // state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic: each state waits on exactly one handshake condition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_v_i)        w_state_next = cmd_we_i ? S_WADDR : S_RADDR;
            S_WADDR: if (w_wr_done)      w_state_next = S_WRESP;
            S_WRESP: if (m_axi_bvalid)   w_state_next = S_RSP;
            S_RADDR: if (m_axi_arready)  w_state_next = S_RDATA;
            S_RDATA: if (m_axi_rvalid)   w_state_next = S_RSP;
            S_RSP:   if (rsp_yumi_i)     w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    // latch the command on accept; held stable until the next accept
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else if (w_cmd_fire) begin
            r_we   <= cmd_we_i;
            r_addr <= cmd_addr_i;
            r_data <= cmd_data_i;
            r_strb <= cmd_strb_i;
        end
    end

    // track AW/W completion; both flags clear together when leaving WADDR
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == S_WADDR) begin
            if (w_wr_done) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_fire) r_aw_done <= 1'b1;
                if (w_w_fire)  r_w_done  <= 1'b1;
            end
        end
    end

    // capture response data/status; writes report zero data
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_b_fire) begin
            r_rsp_data <= '0;
            r_rsp_err  <= (m_axi_bresp != 2'b00);
        end else if (w_r_fire) begin
            r_rsp_data <= m_axi_rdata;
            r_rsp_err  <= (m_axi_rresp != 2'b00);
        end
    end

    // saturating count of non-OKAY responses; holds at all-ones
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_count <= '0;
        end else if (w_cap_err && (r_err_count != {err_count_width_p{1'b1}})) begin
            r_err_count <= r_err_count + err_count_width_p'(1);
        end
    end

endmodule

// File: tb/tb_bsg_zynq_axil_master.sv
// tb_bsg_zynq_axil_master
// Directed bench: a small reactive AXI-Lite slave with programmable ready
// and response latencies, driven by hand-built command sequences with
// hand-computed expected timing and data.
module tb_bsg_zynq_axil_master;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int EW = 8;
    localparam int SW = DW / 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic          cmd_v, cmd_we, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_strb;
    logic          rsp_v, rsp_yumi, rsp_we, rsp_err;
    logic [DW-1:0] rsp_data;
    logic [EW-1:0] err_count;

    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    // slave configuration
    int            cfg_aw_lat, cfg_w_lat, cfg_ar_lat, cfg_r_lat;
    logic [1:0]    cfg_bresp, cfg_rresp;
    logic [DW-1:0] cfg_rdata;

    // slave state and monitors
    int   aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, b_pend, r_pend;
    int   aw_beats, w_beats, b_beats, bready_early;

    int n_cmp = 0;
    int n_mis = 0;

    bsg_zynq_axil_master #(
        .C_M_AXI_DATA_WIDTH (DW),
        .C_M_AXI_ADDR_WIDTH (AW),
        .err_count_width_p  (EW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_v_i       (cmd_v),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_addr_i    (cmd_addr),
        .cmd_data_i    (cmd_data),
        .cmd_strb_i    (cmd_strb),
        .rsp_v_o       (rsp_v),
        .rsp_yumi_i    (rsp_yumi),
        .rsp_data_o    (rsp_data),
        .rsp_we_o      (rsp_we),
        .rsp_err_o     (rsp_err),
        .err_count_o   (err_count),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    // slave: ready after a programmable number of valid cycles; responses one cycle later
    assign awready = awvalid && (aw_cnt >= cfg_aw_lat);
    assign wready  = wvalid  && (w_cnt  >= cfg_w_lat);
    assign arready = arvalid && (ar_cnt >= cfg_ar_lat);
    assign bvalid  = b_pend;
    assign bresp   = cfg_bresp;
    assign rvalid  = r_pend && (r_cnt >= cfg_r_lat);
    assign rdata   = cfg_rdata;
    assign rresp   = cfg_rresp;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_beats <= 0; w_beats <= 0; b_beats <= 0; bready_early <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            r_cnt  <= (r_pend  && !rvalid)  ? r_cnt  + 1 : 0;
            if (bvalid && bready) begin
                b_pend <= 1'b0;
            end else if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (awvalid && awready) aw_got <= 1'b1;
                if (wvalid && wready)   w_got  <= 1'b1;
            end
            if (rvalid && rready)        r_pend <= 1'b0;
            else if (arvalid && arready) r_pend <= 1'b1;
            if (awvalid && awready) aw_beats <= aw_beats + 1;
            if (wvalid && wready)   w_beats  <= w_beats + 1;
            if (bvalid && bready)   b_beats  <= b_beats + 1;
            if (bready && (aw_beats <= b_beats || w_beats <= b_beats))
                bready_early <= bready_early + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge of cycle N+1 (N = accept cycle)
    task automatic send_cmd(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb);
        int n = 0;
        cmd_v = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_strb = strb;
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check_eq("cmd_accept", cmd_ready, 1'b1);
        @(negedge aclk);
        cmd_v = 1'b0;
    endtask

    // advance until rsp_v; lat counts cycles after accept
    task automatic wait_rsp_v(input int start, output int lat);
        lat = start;
        while (!rsp_v && lat < 300) begin
            @(negedge aclk);
            lat++;
        end
        check_eq("rsp_v", rsp_v, 1'b1);
    endtask

    task automatic finish_rsp(input string tag, input int start, input int exp_lat,
                              input logic exp_we, input logic [DW-1:0] exp_data,
                              input logic exp_err);
        int lat;
        wait_rsp_v(start, lat);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_we"}, rsp_we, exp_we);
        check_eq({tag, "_data"}, rsp_data, exp_data);
        check_eq({tag, "_err"}, rsp_err, exp_err);
        $display("txn %s: we=%0d data=0x%08h err=%0d latency=%0d err_count=%0d",
                 tag, rsp_we, rsp_data, rsp_err, lat, err_count);
        rsp_yumi = 1'b1;
        @(negedge aclk);
        rsp_yumi = 1'b0;
        check_eq({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw0, w0, lat;
        cmd_v = 0; cmd_we = 0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0; rsp_yumi = 0;
        cfg_aw_lat = 0; cfg_w_lat = 0; cfg_ar_lat = 0; cfg_r_lat = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;

        // reset state
        repeat (3) @(negedge aclk);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        check_eq("rst_readies", {bready, rready}, 2'b00);
        check_eq("rst_rsp_v", rsp_v, 1'b0);
        check_eq("rst_rsp_fields", {rsp_data, rsp_we, rsp_err}, '0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_axi_payload", {awaddr, araddr, wdata, wstrb}, '0);
        aresetn = 1'b1;
        @(negedge aclk);

        // basic write, slave ready immediately
        send_cmd(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        check_eq("wr_awvalid_n1", awvalid, 1'b1);
        check_eq("wr_wvalid_n1", wvalid, 1'b1);
        check_eq("wr_awaddr", awaddr, 10'h010);
        check_eq("wr_wdata", wdata, 32'hDEADBEEF);
        check_eq("wr_wstrb", wstrb, 4'hF);
        check_eq("wr_awprot", awprot, 3'b000);
        @(negedge aclk);
        check_eq("wr_bready_n2", bready, 1'b1);
        check_eq("wr_valids_low_n2", {awvalid, wvalid}, 2'b00);
        finish_rsp("wr_basic", 2, 3, 1'b1, 32'h0, 1'b0);

        // write with W accepted 3 cycles before AW
        cfg_aw_lat = 3;
        aw0 = aw_beats; w0 = w_beats;
        send_cmd(1'b1, 10'h020, 32'hA5A50F0F, 4'h3);
        check_eq("skew_both_valid_n1", {awvalid, wvalid}, 2'b11);
        check_eq("skew_wstrb", wstrb, 4'h3);
        @(negedge aclk);
        check_eq("skew_n2_aw_w", {awvalid, wvalid, bready}, 3'b100);
        @(negedge aclk);
        check_eq("skew_n3_aw_w", {awvalid, wvalid, bready}, 3'b100);
        check_eq("skew_awaddr_stable", awaddr, 10'h020);
        @(negedge aclk);
        check_eq("skew_n4_aw_w", {awvalid, wvalid, bready}, 3'b100);
        @(negedge aclk);
        check_eq("skew_n5_bready", {awvalid, wvalid, bready}, 3'b001);
        finish_rsp("wr_skew", 5, 6, 1'b1, 32'h0, 1'b0);
        check_eq("skew_aw_beats", aw_beats - aw0, 1);
        check_eq("skew_w_beats", w_beats - w0, 1);
        check_eq("skew_bready_early", bready_early, 0);
        cfg_aw_lat = 0;

        // read with arready held low for 2 cycles
        cfg_ar_lat = 2; cfg_rdata = 32'h12345678;
        send_cmd(1'b0, 10'h008, 32'hFFFFFFFF, 4'hF);
        check_eq("rd_n1_arvalid", {arvalid, rready}, 2'b10);
        check_eq("rd_n1_araddr", araddr, 10'h008);
        @(negedge aclk);
        check_eq("rd_n2_arvalid", {arvalid, rready}, 2'b10);
        check_eq("rd_n2_araddr", araddr, 10'h008);
        @(negedge aclk);
        check_eq("rd_n3_arvalid", {arvalid, rready}, 2'b10);
        check_eq("rd_n3_araddr", araddr, 10'h008);
        @(negedge aclk);
        check_eq("rd_n4_rready", {arvalid, rready}, 2'b01);
        finish_rsp("rd_stall", 4, 5, 1'b0, 32'h12345678, 1'b0);
        cfg_ar_lat = 0;

        // error responses
        check_eq("err_count_0", err_count, 0);
        cfg_rresp = 2'b10; cfg_rdata = 32'h0000BEEF;
        send_cmd(1'b0, 10'h00C, 32'h0, 4'h0);
        finish_rsp("rd_err", 1, 3, 1'b0, 32'h0000BEEF, 1'b1);
        check_eq("err_count_1", err_count, 1);
        cfg_rresp = 2'b00; cfg_bresp = 2'b11;
        send_cmd(1'b1, 10'h014, 32'h11223344, 4'hF);
        finish_rsp("wr_err", 1, 3, 1'b1, 32'h0, 1'b1);
        check_eq("err_count_2", err_count, 2);
        cfg_bresp = 2'b00;

        // response back-pressure with a new command waiting
        cfg_rdata = 32'hCAFEF00D;
        send_cmd(1'b0, 10'h018, 32'h0, 4'h0);
        wait_rsp_v(1, lat);
        check_eq("bp_latency", lat, 3);
        cmd_v = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h030; cmd_data = 32'h55AA55AA; cmd_strb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_rsp_v", rsp_v, 1'b1);
            check_eq("bp_hold_data", rsp_data, 32'hCAFEF00D);
            check_eq("bp_hold_we", rsp_we, 1'b0);
            check_eq("bp_hold_cmd_ready", cmd_ready, 1'b0);
            @(negedge aclk);
        end
        $display("txn rd_bp: we=%0d data=0x%08h err=%0d held=5", rsp_we, rsp_data, rsp_err);
        check_eq("bp_yumi_cycle_ready", cmd_ready, 1'b0);
        rsp_yumi = 1'b1;
        @(negedge aclk);
        rsp_yumi = 1'b0;
        check_eq("bp_ready_after_yumi", cmd_ready, 1'b1);
        check_eq("bp_rsp_v_dropped", rsp_v, 1'b0);
        @(negedge aclk);
        cmd_v = 1'b0;
        check_eq("bp_new_awvalid", awvalid, 1'b1);
        check_eq("bp_new_awaddr", awaddr, 10'h030);
        check_eq("bp_new_wdata", wdata, 32'h55AA55AA);
        finish_rsp("wr_after_bp", 1, 3, 1'b1, 32'h0, 1'b0);
        check_eq("err_count_still_2", err_count, 2);

        // saturation: 256 further error responses from a count of 2
        cfg_rresp = 2'b10; cfg_rdata = 32'h0;
        for (int i = 0; i < 253; i++) begin
            send_cmd(1'b0, 10'h040, 32'h0, 4'h0);
            finish_rsp("rd_sat", 1, 3, 1'b0, 32'h0, 1'b1);
        end
        check_eq("err_count_reach_ff", err_count, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            send_cmd(1'b0, 10'h044, 32'h0, 4'h0);
            finish_rsp("rd_sat_hold", 1, 3, 1'b0, 32'h0, 1'b1);
        end
        check_eq("err_count_saturated", err_count, 8'hFF);
        cfg_rresp = 2'b00;

        // async reset while waiting in RDATA
        cfg_r_lat = 10; cfg_rdata = 32'h0BADCAFE;
        send_cmd(1'b0, 10'h004, 32'h0, 4'h0);
        @(negedge aclk);
        check_eq("ar_rst_rready_before", rready, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        check_eq("ar_rst_rready", rready, 1'b0);
        check_eq("ar_rst_valids", {awvalid, wvalid, arvalid, bready}, 4'b0000);
        check_eq("ar_rst_rsp_v", rsp_v, 1'b0);
        check_eq("ar_rst_err_count", err_count, 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cfg_r_lat = 0;
        check_eq("post_rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("post_rst_err_count", err_count, 0);
        send_cmd(1'b0, 10'h004, 32'h0, 4'h0);
        check_eq("post_rst_arvalid", arvalid, 1'b1);
        check_eq("post_rst_araddr", araddr, 10'h004);
        @(negedge aclk);
        check_eq("post_rst_rready", rready, 1'b1);
        finish_rsp("rd_post_rst", 2, 3, 1'b0, 32'h0BADCAFE, 1'b0);
        check_eq("post_rst_err_count_end", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
